// File: rtl/riscv_dmem_responder_if.sv
// Data-port bus between the RISC-V core (master) and the data-memory responder (slave).
// Handshake: the master holds data_rd_en_ma or data_wr_en_ma with addr/wr/ctrl stable until a
// rising edge finds the responder idle; that edge takes the request. The responder answers with a
// single-cycle data_ready, qualified by data_err. data_rd and data_err are zero outside that pulse,
// and requests presented while the responder is busy are ignored, not queued.
interface riscv_dmem_responder_if #(
   parameter int P_DATA_WIDTH      = 32,
   parameter int P_DMEM_ADDR_WIDTH = 32
);
   logic [P_DMEM_ADDR_WIDTH-1:0] data_addr;
   logic [P_DATA_WIDTH-1:0]      data_wr;
   logic                         data_wr_en_ma;
   logic                         data_rd_en_ma;
   logic [3:0]                   data_rd_en_ctrl;
   logic [P_DATA_WIDTH-1:0]      data_rd;
   logic                         data_ready;
   logic                         data_err;

   modport master (
      output data_addr, data_wr, data_wr_en_ma, data_rd_en_ma, data_rd_en_ctrl,
      input  data_rd, data_ready, data_err
   );

   modport slave (
      input  data_addr, data_wr, data_wr_en_ma, data_rd_en_ma, data_rd_en_ctrl,
      output data_rd, data_ready, data_err
   );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Data-memory slave for the RISC-V data port: programmable wait states, byte-lane stores,
// sign/zero-extended loads and a one-cycle response pulse flagged on misaligned/illegal accesses.
module riscv_dmem_responder #(
   parameter int P_DATA_WIDTH      = 32,
   parameter int P_DMEM_ADDR_WIDTH = 32,
   parameter int P_MEM_DEPTH       = 1024,
   parameter int P_WAIT_STATES     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   riscv_dmem_responder_if.slave bus,
   output logic [1:0]            dbg_state
);
   localparam int         IDX_W     = $clog2(P_MEM_DEPTH);
   localparam logic [3:0] WAIT_INIT = 4'(P_WAIT_STATES);

   // Debug encoding: 0 idle, 1 waiting, 2 responding.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                       state_q, state_d;
   logic [3:0]                   cnt_q, cnt_d;
   logic                         accept;
   logic [P_DMEM_ADDR_WIDTH-1:0] addr_q;
   logic [P_DATA_WIDTH-1:0]      wdata_q;
   logic [3:0]                   ctrl_q;
   logic                         rd_q, wr_q;

   logic [P_DATA_WIDTH-1:0]      mem [P_MEM_DEPTH];
   logic [IDX_W-1:0]             idx;
   logic [P_DATA_WIDTH-1:0]      word;
   logic [2:0]                   f3;
   logic                         ctrl_illegal, misaligned, err;
   logic [7:0]                   lane_byte;
   logic [15:0]                  lane_half;
   logic [P_DATA_WIDTH-1:0]      load_val;
   logic [3:0]                   be;
   logic [P_DATA_WIDTH-1:0]      wide;
   logic                         resp, do_write;
   logic                         unused_addr;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.data_rd_en_ma || bus.data_wr_en_ma) begin
               accept  = 1'b1;
               cnt_d   = WAIT_INIT;
               state_d = (P_WAIT_STATES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = S_RESP;
         end
         S_RESP: begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
         end
         default: begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         ctrl_q  <= 4'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= bus.data_addr;
            wdata_q <= bus.data_wr;
            ctrl_q  <= bus.data_rd_en_ctrl;
            rd_q    <= bus.data_rd_en_ma;
            wr_q    <= bus.data_wr_en_ma;
         end
      end
   end

   // Upper address bits alias onto the same words.
   assign unused_addr = ^addr_q;
   assign idx         = addr_q[IDX_W+1:2];
   assign word        = mem[idx];
   assign f3          = ctrl_q[2:0];

   always_comb begin
      ctrl_illegal = ctrl_q[3] || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)
                     || (wr_q && f3[2]);
      misaligned   = ((f3[1:0] == 2'b01) && addr_q[0])
                     || ((f3[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
      err          = ctrl_illegal || misaligned || (rd_q && wr_q);
   end

   always_comb begin
      lane_byte = word[{addr_q[1:0], 3'b000} +: 8];
      lane_half = addr_q[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
         3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
         3'b010:  load_val = word;
         3'b100:  load_val = {24'd0, lane_byte};
         3'b101:  load_val = {16'd0, lane_half};
         default: load_val = '0;
      endcase
   end

   // Store data is replicated across lanes so the byte enables alone pick the target bytes.
   always_comb begin
      be   = 4'b0000;
      wide = wdata_q;
      case (f3[1:0])
         2'b00: begin
            be   = 4'b0001 << addr_q[1:0];
            wide = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be   = addr_q[1] ? 4'b1100 : 4'b0011;
            wide = {2{wdata_q[15:0]}};
         end
         2'b10:   be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   assign resp     = (state_q == S_RESP);
   assign do_write = resp && wr_q && !err;

   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wide[8*i +: 8];
         end
      end
   end

   always_comb begin
      bus.data_ready = resp;
      bus.data_err   = resp && err;
      bus.data_rd    = (resp && rd_q && !err) ? load_val : '0;
   end

   assign dbg_state = state_q;
endmodule
